reg_slice_forward_pipe: RTL and testbench

REG_SLICE_FORWARD_PIPE -- requirements
Module: reg_slice_forward_pipe

---
 rtl/rs_pkg.sv | 12 +
 rtl/rs_fwd_stage.sv | 44 ++++
 rtl/reg_slice_forward_pipe.sv | 55 +++++
 tb/tb_reg_slice_forward_pipe.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared defaults and helpers for the forward register-slice pipe.
package rs_pkg;

   localparam int PLD_WIDTH_DEF = 32;
   localparam int DEPTH_DEF     = 2;

   // Bits needed to count 0..depth occupied stages.
   function automatic int occ_w(input int depth);
      return (depth < 1) ? 1 : $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/rs_fwd_stage.sv
// One forward register stage: a valid flop plus payload register with
// bubble-collapsing ready (empty stage always accepts).
module rs_fwd_stage
   import rs_pkg::*;
#(
   parameter int PLD_WIDTH = PLD_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_vld,
   input  logic [PLD_WIDTH-1:0] in_pld,
   output logic                 in_rdy,
   output logic                 out_vld,
   output logic [PLD_WIDTH-1:0] out_pld,
   input  logic                 out_rdy
);

   logic                 vld_q, vld_d;
   logic [PLD_WIDTH-1:0] pld_q, pld_d;

   assign in_rdy = !vld_q | out_rdy;

   always_comb begin
      vld_d = vld_q;
      pld_d = pld_q;
      if (in_rdy) vld_d = in_vld;
      // payload only moves with a real beat so bubbles never toggle it
      if (in_rdy && in_vld) pld_d = in_pld;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= 1'b0;
         pld_q <= '0;
      end else begin
         vld_q <= vld_d;
         pld_q <= pld_d;
      end
   end

   assign out_vld = vld_q;
   assign out_pld = pld_q;

endmodule

// File: rtl/reg_slice_forward_pipe.sv
// DEPTH-stage forward-registered pipe; valid/payload are flopped per stage,
// ready ripples combinationally from m_rdy back to s_rdy.
module reg_slice_forward_pipe
   import rs_pkg::*;
#(
   parameter int PLD_WIDTH = PLD_WIDTH_DEF,
   parameter int DEPTH     = DEPTH_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      s_vld,
   input  logic [PLD_WIDTH-1:0]      s_pld,
   output logic                      s_rdy,
   output logic                      m_vld,
   output logic [PLD_WIDTH-1:0]      m_pld,
   input  logic                      m_rdy,
   output logic [occ_w(DEPTH)-1:0]   occ
);

   localparam int OCC_W = occ_w(DEPTH);

   // index k is the input of stage k; index DEPTH is the pipe output
   logic [DEPTH:0]       stg_vld;
   logic [DEPTH:0]       stg_rdy;
   logic [PLD_WIDTH-1:0] stg_pld [DEPTH+1];
   logic [OCC_W-1:0]     occ_sum;

   assign stg_vld[0]     = s_vld;
   assign stg_pld[0]     = s_pld;
   assign stg_rdy[DEPTH] = m_rdy;

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      rs_fwd_stage #(.PLD_WIDTH(PLD_WIDTH)) u_stage (
         .clk     (clk),
         .rst     (rst),
         .in_vld  (stg_vld[k]),
         .in_pld  (stg_pld[k]),
         .in_rdy  (stg_rdy[k]),
         .out_vld (stg_vld[k+1]),
         .out_pld (stg_pld[k+1]),
         .out_rdy (stg_rdy[k+1])
      );
   end

   always_comb begin
      occ_sum = '0;
      for (int k = 1; k <= DEPTH; k++) occ_sum = occ_sum + OCC_W'(stg_vld[k]);
   end

   assign s_rdy = stg_rdy[0];
   assign m_vld = stg_vld[DEPTH];
   assign m_pld = stg_pld[DEPTH];
   assign occ   = occ_sum;

endmodule

// File: tb/tb_reg_slice_forward_pipe.sv
// Directed + scoreboard bench for reg_slice_forward_pipe at DEPTH 1..4.
module tb_reg_slice_forward_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  s_vld = '0;
   logic [3:0]  m_rdy = '0;
   logic [3:0]  s_rdy;
   logic [3:0]  m_vld;
   logic [31:0] s_pld [4];
   logic [31:0] m_pld [4];
   logic [0:0]  occ1;
   logic [1:0]  occ2;
   logic [1:0]  occ3;
   logic [2:0]  occ4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // instance idx n has DEPTH n+1
   reg_slice_forward_pipe #(.PLD_WIDTH(32), .DEPTH(1)) u_d1 (
      .clk(clk), .rst(rst), .s_vld(s_vld[0]), .s_pld(s_pld[0]), .s_rdy(s_rdy[0]),
      .m_vld(m_vld[0]), .m_pld(m_pld[0]), .m_rdy(m_rdy[0]), .occ(occ1));
   reg_slice_forward_pipe #(.PLD_WIDTH(32), .DEPTH(2)) u_d2 (
      .clk(clk), .rst(rst), .s_vld(s_vld[1]), .s_pld(s_pld[1]), .s_rdy(s_rdy[1]),
      .m_vld(m_vld[1]), .m_pld(m_pld[1]), .m_rdy(m_rdy[1]), .occ(occ2));
   reg_slice_forward_pipe #(.PLD_WIDTH(32), .DEPTH(3)) u_d3 (
      .clk(clk), .rst(rst), .s_vld(s_vld[2]), .s_pld(s_pld[2]), .s_rdy(s_rdy[2]),
      .m_vld(m_vld[2]), .m_pld(m_pld[2]), .m_rdy(m_rdy[2]), .occ(occ3));
   reg_slice_forward_pipe #(.PLD_WIDTH(32), .DEPTH(4)) u_d4 (
      .clk(clk), .rst(rst), .s_vld(s_vld[3]), .s_pld(s_pld[3]), .s_rdy(s_rdy[3]),
      .m_vld(m_vld[3]), .m_pld(m_pld[3]), .m_rdy(m_rdy[3]), .occ(occ4));

   function automatic int get_occ(input int idx);
      case (idx)
         0:       return int'(occ1);
         1:       return int'(occ2);
         2:       return int'(occ3);
         default: return int'(occ4);
      endcase
   endfunction

   // inputs change 1 time unit after the rising edge, outputs sampled 1 later
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      s_vld = '0;
      rst   = 1'b1;
      cyc();
      rst   = 1'b0;
   endtask

   task automatic test_reset();
      s_vld = 4'hF;
      m_rdy = 4'h0;
      for (int i = 0; i < 4; i++) s_pld[i] = 32'hA5;
      rst = 1'b1;
      repeat (3) cyc();
      rst   = 1'b0;
      s_vld = '0;
      #1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (m_vld[i] !== 1'b0) begin
            errors++; $display("FAIL reset_m_vld d%0d got %b want 0", i + 1, m_vld[i]);
         end
         checks++;
         if (m_pld[i] !== 32'h0) begin
            errors++; $display("FAIL reset_m_pld d%0d got %h want 0", i + 1, m_pld[i]);
         end
         checks++;
         if (get_occ(i) !== 0) begin
            errors++; $display("FAIL reset_occ d%0d got %0d want 0", i + 1, get_occ(i));
         end
         checks++;
         if (s_rdy[i] !== 1'b1) begin
            errors++; $display("FAIL reset_s_rdy d%0d got %b want 1", i + 1, s_rdy[i]);
         end
      end
      m_rdy = 4'hF;
      repeat (5) begin
         cyc();
         checks++;
         if (m_vld !== 4'h0) begin
            errors++; $display("FAIL reset_no_emit got %b want 0000", m_vld);
         end
      end
   endtask

   // 10 beats 1..10 with m_rdy=1: each appears exactly DEPTH cycles later
   task automatic test_stream(input int idx);
      int d;
      d = idx + 1;
      m_rdy[idx] = 1'b1;
      for (int t = 0; t < 10 + d + 2; t++) begin
         s_vld[idx] = (t < 10);
         s_pld[idx] = 32'(t + 1);
         #1;
         checks++;
         if (m_vld[idx] !== ((t >= d) && (t < 10 + d))) begin
            errors++; $display("FAIL stream_vld d%0d t%0d got %b", d, t, m_vld[idx]);
         end
         if (t >= d && t < 10 + d) begin
            checks++;
            if (m_pld[idx] !== 32'(t - d + 1)) begin
               errors++;
               $display("FAIL stream_pld d%0d t%0d got %0d want %0d", d, t, m_pld[idx], t - d + 1);
            end
         end
         checks++;
         if (s_rdy[idx] !== 1'b1) begin
            errors++; $display("FAIL stream_s_rdy d%0d t%0d got %b want 1", d, t, s_rdy[idx]);
         end
         cyc();
      end
      s_vld[idx] = 1'b0;
   endtask

   task automatic test_backpressure();
      m_rdy[1] = 1'b0;
      s_vld[1] = 1'b1; s_pld[1] = 32'h11; cyc();
      s_pld[1] = 32'h22; #1;
      checks++;
      if (s_rdy[1] !== 1'b1) begin
         errors++; $display("FAIL bp_second_accept got %b want 1", s_rdy[1]);
      end
      cyc();
      s_pld[1] = 32'h33;
      repeat (3) begin
         #1;
         checks++;
         if (s_rdy[1] !== 1'b0 || get_occ(1) !== 2) begin
            errors++; $display("FAIL bp_full s_rdy %b occ %0d want 0/2", s_rdy[1], get_occ(1));
         end
         checks++;
         if (m_vld[1] !== 1'b1 || m_pld[1] !== 32'h11) begin
            errors++; $display("FAIL bp_hold vld %b pld %h want 1/11", m_vld[1], m_pld[1]);
         end
         cyc();
      end
      m_rdy[1] = 1'b1; #1;
      checks++;
      if (s_rdy[1] !== 1'b1) begin
         errors++; $display("FAIL bp_release_s_rdy got %b want 1", s_rdy[1]);
      end
      cyc();
      s_vld[1] = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++;
         if (m_vld[1] !== 1'b1 || m_pld[1] !== 32'(8'h22 + 8'h11 * k)) begin
            errors++; $display("FAIL bp_drain%0d vld %b pld %h", k, m_vld[1], m_pld[1]);
         end
         cyc();
      end
      #1;
      checks++;
      if (m_vld[1] !== 1'b0 || get_occ(1) !== 0) begin
         errors++; $display("FAIL bp_empty vld %b occ %0d want 0/0", m_vld[1], get_occ(1));
      end
   endtask

   task automatic test_bubble();
      m_rdy[2] = 1'b0;
      s_vld[2] = 1'b1; s_pld[2] = 32'h7;
      cyc();
      s_vld[2] = 1'b0;
      #1;
      checks++;
      if (get_occ(2) !== 1 || m_vld[2] !== 1'b0) begin
         errors++; $display("FAIL bubble_stage0 occ %0d vld %b want 1/0", get_occ(2), m_vld[2]);
      end
      repeat (2) cyc();
      repeat (2) begin
         checks++;
         if (m_vld[2] !== 1'b1 || m_pld[2] !== 32'h7) begin
            errors++; $display("FAIL bubble_out vld %b pld %h want 1/7", m_vld[2], m_pld[2]);
         end
         checks++;
         if (get_occ(2) !== 1 || s_rdy[2] !== 1'b1) begin
            errors++; $display("FAIL bubble_occ occ %0d s_rdy %b want 1/1", get_occ(2), s_rdy[2]);
         end
         cyc();
      end
      m_rdy[2] = 1'b1;
      cyc();
      checks++;
      if (m_vld[2] !== 1'b0) begin
         errors++; $display("FAIL bubble_drain got %b want 0", m_vld[2]);
      end
   endtask

   task automatic test_midrun_reset();
      m_rdy[1] = 1'b0;
      s_vld[1] = 1'b1; s_pld[1] = 32'hB1; cyc();
      s_pld[1] = 32'hB2; cyc();
      s_vld[1] = 1'b0; #1;
      checks++;
      if (get_occ(1) !== 2) begin
         errors++; $display("FAIL mid_pre_occ got %0d want 2", get_occ(1));
      end
      rst = 1'b1; cyc();
      rst = 1'b0; #1;
      checks++;
      if (get_occ(1) !== 0 || m_vld[1] !== 1'b0 || m_pld[1] !== 32'h0) begin
         errors++;
         $display("FAIL mid_rst occ %0d vld %b pld %h want 0/0/0", get_occ(1), m_vld[1], m_pld[1]);
      end
      m_rdy[1] = 1'b1;
      repeat (4) begin
         cyc();
         checks++;
         if (m_vld[1] !== 1'b0) begin
            errors++; $display("FAIL mid_ghost got vld 1 pld %h", m_pld[1]);
         end
      end
   endtask

   task automatic test_random(input int idx);
      logic [31:0] sb [$];
      logic [31:0] nxt, prev_pld, exp;
      logic        prev_stall;
      int          d;
      d = idx + 1;
      pulse_reset();
      nxt = 32'h1000;
      prev_stall = 1'b0;
      prev_pld = '0;
      for (int t = 0; t < 1000 + d + 4; t++) begin
         s_vld[idx] = (t < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
         m_rdy[idx] = (t < 1000) ? 1'($urandom_range(0, 1)) : 1'b1;
         s_pld[idx] = nxt;
         #1;
         if (prev_stall) begin
            checks++;
            if (m_vld[idx] !== 1'b1 || m_pld[idx] !== prev_pld) begin
               errors++;
               $display("FAIL rnd_stall d%0d t%0d vld %b pld %h want 1/%h", d, t, m_vld[idx], m_pld[idx], prev_pld);
            end
         end
         checks++;
         if (s_rdy[idx] !== !(get_occ(idx) == d && !m_rdy[idx])) begin
            errors++; $display("FAIL rnd_s_rdy d%0d t%0d got %b occ %0d", d, t, s_rdy[idx], get_occ(idx));
         end
         if (m_vld[idx] && m_rdy[idx]) begin
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL rnd_dup d%0d t%0d got %h want none", d, t, m_pld[idx]);
            end else begin
               exp = sb.pop_front();
               if (m_pld[idx] !== exp) begin
                  errors++; $display("FAIL rnd_order d%0d t%0d got %h want %h", d, t, m_pld[idx], exp);
               end
            end
         end
         if (s_vld[idx] && s_rdy[idx]) begin
            sb.push_back(nxt);
            nxt = nxt + 1;
         end
         prev_stall = m_vld[idx] && !m_rdy[idx];
         prev_pld   = m_pld[idx];
         cyc();
      end
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL rnd_loss d%0d got %0d left want 0", d, sb.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) s_pld[i] = '0;
      cyc();
      test_reset();
      test_stream(1);
      test_stream(0);
      test_backpressure();
      test_bubble();
      test_midrun_reset();
      test_random(0);
      test_random(1);
      test_random(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
